div_clk_monitor: RTL and testbench
==================================

DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

Interface
REQ-001 SHALL have parameter DIV, default 9, meaning the expected divided-clock period in clk cycles (odd, 3..15).
REQ-002 SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive good periods required to assert lock.
REQ-003 SHALL have parameter TMO, default 2*DIV, meaning the number of clk cycles without a rising edge before stuck is declared.
REQ-004 SHALL have port clk  input  1  system clock; one clock domain, all state on posedge clk.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port clk_div9  input  1  divided clock from the odd divider; treated as asynchronous data.
REQ-007 SHALL have port rise  output  1  one-cycle pulse per detected rising edge of clk_div9.
REQ-008 SHALL have port period  output  5  last measured rise-to-rise interval in clk cycles.
REQ-009 SHALL have port lock  output  1  level; divided clock has been verified good.
REQ-010 SHALL have port err  output  1  one-cycle pulse on a bad period or bad high time.
REQ-011 SHALL have port stuck  output  1  one-cycle pulse on timeout.

Function
REQ-012 SHALL synchronise clk_div9 through two flops (s1, s2), then register s2 into s3; edge = s2 & ~s3.
REQ-013 SHALL register rise from edge, so an input rising edge sampled at posedge k produces rise high in cycle k+3.
REQ-014 SHALL run a 5-bit interval counter: set to 1 on an edge cycle, otherwise +1, saturating at 31.
REQ-015 SHALL run a 5-bit high counter: cleared on an edge cycle, +1 on each cycle with s2=1, saturating at 31.
REQ-016 SHALL, on each edge cycle, load period with the interval counter value from before the update; a good period is one equal to DIV.
REQ-017 SHALL define a good high time as a high-count value of (DIV-1)/2 or (DIV+1)/2, captured on the edge cycle.
REQ-018 SHALL implement the FSM states IDLE, ACQ and LOCKED.
REQ-019 SHALL, in IDLE on the first edge, go to ACQ with good_cnt=0 and SHALL not check that interval.
REQ-020 SHALL, in ACQ on an edge with good period and high time, increment good_cnt; on reaching LOCK_CNT it SHALL go to LOCKED.
REQ-021 SHALL, in ACQ on a bad edge, pulse err and clear good_cnt while staying in ACQ.
REQ-022 SHALL, in LOCKED on a bad edge, pulse err, deassert lock the next cycle, clear good_cnt and go to ACQ.
REQ-023 SHALL, in ACQ or LOCKED when the interval counter reaches TMO without an edge, pulse stuck once, go to IDLE and drop lock.
REQ-024 SHALL, when a timeout and an edge occur in the same cycle, give the edge priority; no stuck pulse is raised.
REQ-025 SHALL register lock: lock=1 exactly while the state is LOCKED.
REQ-026 SHALL register err and stuck and SHALL never assert them in the same cycle.

Reset
REQ-027 SHALL, while rst=1 at posedge clk, clear s1..s3, both counters, good_cnt, period, rise, lock, err and stuck, and set the state to IDLE.
REQ-028 SHALL treat reset mid-operation the same as initial reset; the first edge after reset goes through IDLE with no err.
REQ-029 SHALL, with rst held, keep all outputs at 0 regardless of clk_div9.

Structure
REQ-030 SHALL define the FSM state enumeration and the 5-bit counter width constant in the shared divider package div_pkg.
REQ-031 SHALL place the 2-flop synchroniser plus edge register in sub-module div_edge_sync (ports clk, rst, d, rise_edge, level); all other logic stays in the top level.
REQ-032 SHALL contain no latches and no logic clocked by clk_div9.

Verification
REQ-033 SHALL cover: a clean divide-by-9 source (high 4.5 cycles) -> rise every 9 cycles, period=9, lock=1 on the 5th edge after reset, err never.
REQ-034 SHALL cover: one period stretched to 10 while LOCKED -> err pulse on that edge, lock=0 the next cycle, re-lock after 4 further good periods.
REQ-035 SHALL cover: clk_div9 held low for 18 cycles after lock -> single stuck pulse, lock=0, state IDLE, first subsequent edge produces no err.
REQ-036 SHALL cover: a 9-cycle period with high time 2 cycles -> err pulse, period=9, good_cnt cleared.
REQ-037 SHALL cover: rst asserted for one cycle while LOCKED -> all outputs 0 the next cycle, lock regained after the 5th edge post-reset.
REQ-038 SHALL cover: an edge arriving exactly on the cycle the interval counter reaches TMO -> no stuck pulse, period=18, err pulse.

Source files
------------

// File: rtl/div_pkg.sv
// Shared divider-monitor types: FSM states, counter width and a saturating increment.
// Pure declarations; no timing or flow control.
package div_pkg;

   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/div_edge_sync.sv
// Two-flop synchroniser plus one edge register for an asynchronous level.
// rise_edge is valid two cycles after d is first sampled high; never stalls.
module div_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise_edge,
   output logic level
);

   logic s1, s2, s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise_edge = s2 & ~s3;
   assign level     = s2;

endmodule

// File: rtl/div_clk_monitor.sv
// Checks a divided clock for correct period and high time, tracks lock, flags stuck input.
// All outputs registered, three cycles from input edge sample to rise; no backpressure.
module div_clk_monitor
   import div_pkg::*;
#(
   parameter int DIV      = 9,
   parameter int LOCK_CNT = 4,
   parameter int TMO      = 2 * DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_div9,
   output logic             rise,
   output logic [CNT_W-1:0] period,
   output logic             lock,
   output logic             err,
   output logic             stuck
);

   localparam logic [CNT_W-1:0] DIV_V   = CNT_W'(DIV);
   localparam logic [CNT_W-1:0] TMO_V   = CNT_W'(TMO);
   localparam logic [CNT_W-1:0] LOCK_V  = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0] HI_SHORT = CNT_W'((DIV - 1) / 2);
   localparam logic [CNT_W-1:0] HI_LONG  = CNT_W'((DIV + 1) / 2);

   logic             edge_det;
   logic             lvl;
   logic [CNT_W-1:0] icnt;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] good_cnt;
   logic [CNT_W-1:0] good_cnt_nxt;
   logic [CNT_W-1:0] good_inc;
   state_t           state;
   state_t           state_nxt;
   logic             err_nxt;
   logic             stuck_nxt;
   logic             good_edge;
   logic             timeout;

   div_edge_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .d         (clk_div9),
      .rise_edge (edge_det),
      .level     (lvl)
   );

   // hcnt excludes the edge cycle itself, so a 50% odd divider lands on one of two values
   assign good_edge = (icnt == DIV_V) && ((hcnt == HI_SHORT) || (hcnt == HI_LONG));
   assign timeout   = (icnt == TMO_V);
   assign good_inc  = sat_inc(good_cnt);

   always_comb begin
      state_nxt    = state;
      good_cnt_nxt = good_cnt;
      err_nxt      = 1'b0;
      stuck_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (edge_det) begin
               state_nxt    = ACQ;
               good_cnt_nxt = '0;
            end
         end
         ACQ: begin
            if (edge_det) begin
               if (good_edge) begin
                  good_cnt_nxt = good_inc;
                  if (good_inc >= LOCK_V) state_nxt = LOCKED;
               end else begin
                  err_nxt      = 1'b1;
                  good_cnt_nxt = '0;
               end
            end else if (timeout) begin
               stuck_nxt    = 1'b1;
               state_nxt    = IDLE;
               good_cnt_nxt = '0;
            end
         end
         LOCKED: begin
            // an edge always wins over a coincident timeout
            if (edge_det) begin
               if (!good_edge) begin
                  err_nxt      = 1'b1;
                  good_cnt_nxt = '0;
                  state_nxt    = ACQ;
               end
            end else if (timeout) begin
               stuck_nxt    = 1'b1;
               state_nxt    = IDLE;
               good_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt    = IDLE;
            good_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         good_cnt <= '0;
         icnt     <= '0;
         hcnt     <= '0;
         period   <= '0;
         rise     <= 1'b0;
         lock     <= 1'b0;
         err      <= 1'b0;
         stuck    <= 1'b0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_cnt_nxt;
         rise     <= edge_det;
         icnt     <= edge_det ? CNT_W'(1) : sat_inc(icnt);
         hcnt     <= edge_det ? '0 : (lvl ? sat_inc(hcnt) : hcnt);
         if (edge_det) period <= icnt;
         lock     <= (state_nxt == LOCKED);
         err      <= err_nxt;
         stuck    <= stuck_nxt;
      end
   end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Scoreboard bench: each driven rising edge queues its expected rise cycle, period, err and lock.
// A negedge monitor pops on every rise pulse; scenario tasks add their own inline checks.
module tb_div_clk_monitor;
   import div_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_div9;
   logic       rise;
   logic [4:0] period;
   logic       lock;
   logic       err;
   logic       stuck;

   always #5 clk = ~clk;

   div_clk_monitor #(.DIV(9), .LOCK_CNT(4), .TMO(18)) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_div9 (clk_div9),
      .rise     (rise),
      .period   (period),
      .lock     (lock),
      .err      (err),
      .stuck    (stuck)
   );

   typedef struct {
      int cyc;
      bit chk_p;
      int p;
      bit err;
      bit lock;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   stuck_cnt = 0;
   int   stuck_cyc = -1;
   int   err_orphan = 0;
   int   err_stuck = 0;
   int   last_drive = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rise === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_rise: rise at cycle %0d, none expected", cyc);
         end else begin
            mon_e = sb.pop_front();
            n_chk++;
            if (cyc !== mon_e.cyc)
               $display("FAIL rise_cycle: got %0d want %0d", cyc, mon_e.cyc);
            else n_pass++;
            if (mon_e.chk_p) begin
               n_chk++;
               if (period !== 5'(mon_e.p))
                  $display("FAIL period @%0d: got %0d want %0d", cyc, period, mon_e.p);
               else n_pass++;
            end
            n_chk++;
            if (err !== mon_e.err)
               $display("FAIL err_at_rise @%0d: got %b want %b", cyc, err, mon_e.err);
            else n_pass++;
            n_chk++;
            if (lock !== mon_e.lock)
               $display("FAIL lock_at_rise @%0d: got %b want %b", cyc, lock, mon_e.lock);
            else n_pass++;
         end
      end
      if (err === 1'b1 && rise !== 1'b1) err_orphan++;
      if (err === 1'b1 && stuck === 1'b1) err_stuck++;
      if (stuck === 1'b1) begin
         stuck_cnt++;
         stuck_cyc = cyc;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Called at a negedge; one rising edge, hi samples high then lo samples low.
   task automatic send(input int hi, input int lo, input bit chk_p, input int p,
                       input bit e_err, input bit e_lock);
      exp_t e;
      e.cyc   = cyc + 3;
      e.chk_p = chk_p;
      e.p     = p;
      e.err   = e_err;
      e.lock  = e_lock;
      sb.push_back(e);
      last_drive = cyc;
      clk_div9 = 1'b1;
      repeat (hi) @(negedge clk);
      clk_div9 = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clk_div9 = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_chk++;
         if ({rise, period, lock, err, stuck} !== 9'd0)
            $display("FAIL reset_hold %0d: got %b want 0", i, {rise, period, lock, err, stuck});
         else n_pass++;
         clk_div9 = 1'($urandom_range(0, 1));
      end
      clk_div9 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({rise, period, lock, err, stuck} !== 9'd0)
         $display("FAIL reset_release: got %b want 0", {rise, period, lock, err, stuck});
      else n_pass++;
   endtask

   task automatic test_clean();
      send(5, 4, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) send(5, 4, 1'b1, 9, 1'b0, 1'b0);
      repeat (3) send(5, 4, 1'b1, 9, 1'b0, 1'b1);
      n_chk++;
      if (err_orphan !== 0) $display("FAIL clean_err: got %0d stray err want 0", err_orphan);
      else n_pass++;
   endtask

   task automatic test_stretch();
      send(5, 5, 1'b1, 9, 1'b0, 1'b1);
      send(5, 4, 1'b1, 10, 1'b1, 1'b0);
      n_chk++;
      if (lock !== 1'b0) $display("FAIL stretch_unlock: got %b want 0", lock);
      else n_pass++;
      repeat (3) send(5, 4, 1'b1, 9, 1'b0, 1'b0);
      send(5, 4, 1'b1, 9, 1'b0, 1'b1);
   endtask

   task automatic test_stuck();
      int sc0;
      int c;
      sc0 = stuck_cnt;
      send(5, 4, 1'b1, 9, 1'b0, 1'b1);
      c = last_drive;
      repeat (25) @(negedge clk);
      n_chk++;
      if (stuck_cnt - sc0 !== 1) $display("FAIL stuck_count: got %0d want 1", stuck_cnt - sc0);
      else n_pass++;
      n_chk++;
      if (stuck_cyc !== c + 21) $display("FAIL stuck_cycle: got %0d want %0d", stuck_cyc, c + 21);
      else n_pass++;
      n_chk++;
      if (lock !== 1'b0) $display("FAIL stuck_lock: got %b want 0", lock);
      else n_pass++;
      n_chk++;
      if (dut.state !== IDLE) $display("FAIL stuck_state: got %0d want %0d", dut.state, IDLE);
      else n_pass++;
      send(5, 4, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_high_time();
      send(2, 7, 1'b1, 9, 1'b0, 1'b0);
      send(5, 4, 1'b1, 9, 1'b1, 1'b0);
      n_chk++;
      if (dut.good_cnt !== 5'd0) $display("FAIL high_good_cnt: got %0d want 0", dut.good_cnt);
      else n_pass++;
      repeat (3) send(5, 4, 1'b1, 9, 1'b0, 1'b0);
      send(5, 4, 1'b1, 9, 1'b0, 1'b1);
   endtask

   task automatic test_tmo_edge();
      int sc0;
      sc0 = stuck_cnt;
      send(5, 13, 1'b1, 9, 1'b0, 1'b1);
      send(5, 4, 1'b1, 18, 1'b1, 1'b0);
      n_chk++;
      if (stuck_cnt !== sc0) $display("FAIL tmo_edge_stuck: got %0d pulses want 0", stuck_cnt - sc0);
      else n_pass++;
      repeat (3) send(5, 4, 1'b1, 9, 1'b0, 1'b0);
      send(5, 4, 1'b1, 9, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({rise, period, lock, err, stuck} !== 9'd0)
         $display("FAIL mid_reset_outs: got %b want 0", {rise, period, lock, err, stuck});
      else n_pass++;
      n_chk++;
      if (dut.state !== IDLE) $display("FAIL mid_reset_state: got %0d want %0d", dut.state, IDLE);
      else n_pass++;
      rst = 1'b0;
      send(5, 4, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) send(5, 4, 1'b1, 9, 1'b0, 1'b0);
      send(5, 4, 1'b1, 9, 1'b0, 1'b1);
      n_chk++;
      if (lock !== 1'b1) $display("FAIL mid_reset_relock: got %b want 1", lock);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_clean();
      test_stretch();
      test_stuck();
      test_high_time();
      test_tmo_edge();
      test_reset_mid();
      n_chk++;
      if (sb.size() !== 0) $display("FAIL missing_rise: got %0d unmatched want 0", sb.size());
      else n_pass++;
      n_chk++;
      if (err_orphan !== 0) $display("FAIL stray_err: got %0d want 0", err_orphan);
      else n_pass++;
      n_chk++;
      if (err_stuck !== 0) $display("FAIL err_with_stuck: got %0d want 0", err_stuck);
      else n_pass++;
      n_chk++;
      if (stuck_cnt !== 1) $display("FAIL total_stuck: got %0d want 1", stuck_cnt);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
